// File: rtl/rt_pkg.sv
// Shared types and helpers for the ray dispatch slice: direction field widths,
// colour width, dispatcher FSM states and the direction packing helper.
package rt_pkg;

   localparam int DX_W    = 11;
   localparam int DY_W    = 11;
   localparam int DZ_W    = 9;
   localparam int DIR_W   = DX_W + DY_W + DZ_W;
   localparam int COLOR_W = 12;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DONE} state_t;

   function automatic logic [DIR_W-1:0] pack_dir(input logic [DX_W-1:0] dx,
                                                 input logic [DY_W-1:0] dy,
                                                 input logic [DZ_W-1:0] dz);
      return {dx, dy, dz};
   endfunction

endpackage

// File: rtl/ray_dir_gen.sv
// Combinational ray direction for pixel (x,y): camera base plus a scaled,
// centred pixel offset, wrapping modulo 2^11 on dx/dy; dz passes through.
module ray_dir_gen
   import rt_pkg::*;
#(
   parameter int H_RES   = 64,
   parameter int V_RES   = 48,
   parameter int STEP_SH = 2,
   parameter int XW      = 6,
   parameter int YW      = 6
) (
   input  logic [XW-1:0]    x_i,
   input  logic [YW-1:0]    y_i,
   input  logic [DIR_W-1:0] cam_i,
   output logic [DIR_W-1:0] dir_o
);

   logic [DX_W-1:0] x_off;
   logic [DY_W-1:0] y_off;
   logic [DX_W-1:0] dx;
   logic [DY_W-1:0] dy;

   always_comb begin
      // y grows downwards on screen, so the vertical offset is inverted
      x_off = DX_W'(x_i) - DX_W'(H_RES / 2);
      y_off = DY_W'(V_RES / 2) - DY_W'(y_i);
      dx    = cam_i[DIR_W-1 -: DX_W] + (x_off << STEP_SH);
      dy    = cam_i[DZ_W +: DY_W] + (y_off << STEP_SH);
      dir_o = pack_dir(dx, dy, cam_i[DZ_W-1:0]);
   end

endmodule

// File: rtl/ray_dispatch.sv
// Frame sweeper feeding ray_tracer: per pixel issue dir, wait SETTLE cycles,
// sample colour/hit, write the frame buffer. Optional HIT_COUNT_EN adds hit_count.
module ray_dispatch
   import rt_pkg::*;
#(
   parameter int                 H_RES    = 64,
   parameter int                 V_RES    = 48,
   parameter int                 ADDR_W   = 12,
   parameter int                 SETTLE   = 16,
   parameter int                 STEP_SH  = 2,
   parameter logic [COLOR_W-1:0] BG_COLOR = 12'h000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [DIR_W-1:0]   cam_dir,
   output logic [DIR_W-1:0]   dir,
   input  logic [COLOR_W-1:0] rt_dout,
   input  logic               rt_hit,
   output logic               fb_we,
   output logic [ADDR_W-1:0]  fb_addr,
   output logic [COLOR_W-1:0] fb_data,
   output logic               busy,
   output logic               frame_done
`ifdef HIT_COUNT_EN
   ,
   output logic [ADDR_W:0]    hit_count
`endif
);

   localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
   localparam int CW = $clog2(SETTLE + 1);
   localparam logic [XW-1:0] LAST_X = XW'(H_RES - 1);
   localparam logic [YW-1:0] LAST_Y = YW'(V_RES - 1);

   state_t               state_q, state_d;
   logic [XW-1:0]        x_q, x_d;
   logic [YW-1:0]        y_q, y_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [DIR_W-1:0]     cam_q, cam_d;
   logic [DIR_W-1:0]     dir_q, dir_d;
   logic                 hit_q, hit_d;
   logic [COLOR_W-1:0]   col_q, col_d;
   logic                 we_q, we_d;
   logic [ADDR_W-1:0]    fba_q, fba_d;
   logic [COLOR_W-1:0]   fbd_q, fbd_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [DIR_W-1:0]     gen_dir;
`ifdef HIT_COUNT_EN
   logic [ADDR_W:0]      hc_q, hc_d;
`endif

   ray_dir_gen #(
      .H_RES  (H_RES),
      .V_RES  (V_RES),
      .STEP_SH(STEP_SH),
      .XW     (XW),
      .YW     (YW)
   ) u_dir_gen (
      .x_i  (x_q),
      .y_i  (y_q),
      .cam_i(cam_q),
      .dir_o(gen_dir)
   );

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      cam_d   = cam_q;
      dir_d   = dir_q;
      hit_d   = hit_q;
      col_d   = col_q;
      we_d    = 1'b0;
      fba_d   = fba_q;
      fbd_d   = fbd_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
`ifdef HIT_COUNT_EN
      hc_d    = hc_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               cam_d   = cam_dir;
               x_d     = '0;
               y_d     = '0;
               addr_d  = '0;
               busy_d  = 1'b1;
`ifdef HIT_COUNT_EN
               hc_d    = '0;
`endif
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            dir_d   = gen_dir;
            cnt_d   = CW'(SETTLE - 1);
            state_d = WAIT;
         end
         WAIT: begin
            // dir has now been stable for SETTLE cycles; take the tracer result
            if (cnt_q == '0) begin
               hit_d   = rt_hit;
               col_d   = rt_dout;
               state_d = WRITE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         WRITE: begin
            we_d  = 1'b1;
            fba_d = addr_q;
            fbd_d = hit_q ? col_q : BG_COLOR;
`ifdef HIT_COUNT_EN
            hc_d  = hc_q + (ADDR_W + 1)'(hit_q);
`endif
            if (x_q == LAST_X && y_q == LAST_Y) begin
               state_d = DONE;
            end else begin
               addr_d = addr_q + 1'b1;
               if (x_q == LAST_X) begin
                  x_d = '0;
                  y_d = y_q + 1'b1;
               end else begin
                  x_d = x_q + 1'b1;
               end
               state_d = ISSUE;
            end
         end
         DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         addr_q  <= '0;
         cnt_q   <= '0;
         cam_q   <= '0;
         dir_q   <= '0;
         hit_q   <= 1'b0;
         col_q   <= '0;
         we_q    <= 1'b0;
         fba_q   <= '0;
         fbd_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef HIT_COUNT_EN
         hc_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         cam_q   <= cam_d;
         dir_q   <= dir_d;
         hit_q   <= hit_d;
         col_q   <= col_d;
         we_q    <= we_d;
         fba_q   <= fba_d;
         fbd_q   <= fbd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef HIT_COUNT_EN
         hc_q    <= hc_d;
`endif
      end
   end

   assign dir        = dir_q;
   assign fb_we      = we_q;
   assign fb_addr    = fba_q;
   assign fb_data    = fbd_q;
   assign busy       = busy_q;
   assign frame_done = done_q;
`ifdef HIT_COUNT_EN
   assign hit_count  = hc_q;
`endif

endmodule

// File: tb/tb_ray_dispatch.sv
// Self-checking bench for ray_dispatch on a 4x2 grid: a fake ray tracer derived
// from dir, a pixel-level expectation queue and a per-cycle compare process.
module tb_ray_dispatch;

   localparam int H = 4;
   localparam int V = 2;
   localparam int AW = 3;
   localparam int ST = 3;
   localparam int SH = 2;
   localparam logic [11:0] BG = 12'h123;
   localparam int NPIX = H * V;
   localparam int PER = ST + 2;

   logic clk = 1'b0;
   logic rst, start;
   logic [30:0] cam_dir, dir;
   logic [11:0] rt_dout, fb_data;
   logic rt_hit, fb_we, busy, frame_done;
   logic [AW-1:0] fb_addr;
`ifdef HIT_COUNT_EN
   logic [AW:0] hit_count;
`endif

   always #5 clk = ~clk;

   ray_dispatch #(
      .H_RES(H), .V_RES(V), .ADDR_W(AW), .SETTLE(ST), .STEP_SH(SH), .BG_COLOR(BG)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .cam_dir(cam_dir), .dir(dir),
      .rt_dout(rt_dout), .rt_hit(rt_hit), .fb_we(fb_we), .fb_addr(fb_addr),
      .fb_data(fb_data), .busy(busy), .frame_done(frame_done)
`ifdef HIT_COUNT_EN
      , .hit_count(hit_count)
`endif
   );

   typedef struct {
      int          cyc;
      logic [AW-1:0] addr;
      logic [11:0] data;
      logic [30:0] dir;
   } exp_t;

   exp_t q[$];
   int nerr = 0, nchk = 0;
   int cyc = 0;
   int mode = 0;
   logic [30:0] cur_cam = '0;
   int t_start = 0, exp_done = -1, exp_hits = 0;
   int done_cnt = 0, done_cyc = 0;
   logic [30:0] dir_p0, dir_last;
   logic [11:0] data_last;

   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in tracer: its result is a pure function of the presented direction
   function automatic logic [12:0] tracer(input int m, input logic [30:0] d, input logic [10:0] cdx);
      logic [10:0] rel;
      rel = d[30:20] - cdx;
      case (m)
         0:       return {1'b1, 12'hABC};
         1:       return {1'b0, 12'hFFF};
         default: return {rel[2], d[11:0] ^ d[30:19]};
      endcase
   endfunction

   always_comb {rt_hit, rt_dout} = tracer(mode, dir, cur_cam[30:20]);

   function automatic logic [30:0] exp_dir(input logic [30:0] cam, input int x, input int y);
      int ox, oy;
      logic [10:0] dx, dy;
      ox = (x - H / 2) * (2 ** SH);
      oy = (V / 2 - y) * (2 ** SH);
      dx = cam[30:20] + 11'(ox);
      dy = cam[19:9] + 11'(oy);
      return {dx, dy, cam[8:0]};
   endfunction

   task automatic chk(input string name, input longint act, input longint req);
      nchk++;
      if (act != req) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (fb_we) begin
         if (q.size() == 0) begin
            chk("unexpected_we", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("we_cycle", cyc, e.cyc);
            chk("fb_addr", fb_addr, e.addr);
            chk("fb_data", fb_data, e.data);
            chk("dir", dir, e.dir);
            chk("busy_in_frame", busy, 1);
            if (e.addr == 0) dir_p0 = dir;
            dir_last  = dir;
            data_last = fb_data;
         end
      end
      if (frame_done) begin
         chk("done_cycle", cyc, exp_done);
         chk("done_busy_low", busy, 0);
         chk("done_pending", q.size(), 0);
`ifdef HIT_COUNT_EN
         chk("hit_count", hit_count, exp_hits);
`endif
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic start_frame(input logic [30:0] cam);
      cur_cam = cam;
      @(negedge clk);
      start   = 1'b1;
      cam_dir = cam;
      @(negedge clk);
      start    = 1'b0;
      t_start  = cyc;
      exp_hits = 0;
      chk("busy_rise", busy, 1);
      for (int k = 0; k < NPIX; k++) begin
         exp_t e;
         logic [12:0] r;
         e.dir  = exp_dir(cam, k % H, k / H);
         r      = tracer(mode, e.dir, cam[30:20]);
         e.data = r[12] ? r[11:0] : BG;
         exp_hits += int'(r[12]);
         e.addr = AW'(k);
         e.cyc  = t_start + (k + 1) * PER;
         q.push_back(e);
      end
      exp_done = t_start + NPIX * PER + 1;
   endtask

   task automatic wait_done(input int n0);
      for (int i = 0; i < 300 && done_cnt == n0; i++) @(negedge clk);
      if (done_cnt == n0) chk("done_timeout", 0, 1);
      chk("queue_drained", q.size(), 0);
      exp_done = -1;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_dir"}, dir, 0);
      chk({tag, "_we"}, fb_we, 0);
      chk({tag, "_addr"}, fb_addr, 0);
      chk({tag, "_data"}, fb_data, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, frame_done, 0);
`ifdef HIT_COUNT_EN
      chk({tag, "_hits"}, hit_count, 0);
`endif
   endtask

   initial begin
      int n0;
      rst = 1'b1; start = 1'b0; cam_dir = '0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // basic frame, all hits, known camera
      mode = 0; n0 = done_cnt;
      start_frame({11'd0, 11'd0, 9'd256});
      wait_done(n0);
      chk("lit_dir_p0", dir_p0, {11'h7F8, 11'd4, 9'd256});
      chk("lit_dir_p7", dir_last, {11'd4, 11'd0, 9'd256});
      chk("lit_data", data_last, 12'hABC);
      chk("lit_done_ofs", done_cyc - t_start, 41);

      // all misses
      mode = 1; n0 = done_cnt;
      start_frame(31'($urandom));
      wait_done(n0);
      chk("lit_bg", data_last, 12'h123);

      // dx wrap from max positive; alternating hits
      mode = 2; n0 = done_cnt;
      start_frame({11'h3FF, 11'd0, 9'd5});
      wait_done(n0);
      chk("lit_wrap_dx", dir_last[30:20], 11'h403);
`ifdef HIT_COUNT_EN
      repeat (3) @(negedge clk);
      chk("lit_hit_hold", hit_count, 4);
`endif

      // mid-frame start and camera change are ignored; start during DONE too
      n0 = done_cnt;
      start_frame(31'($urandom));
      while (cyc < t_start + 12) @(negedge clk);
      start = 1'b1; cam_dir = 31'($urandom);
      @(negedge clk);
      start = 1'b0;
      while (cyc < t_start + NPIX * PER) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(n0);
      repeat (4) @(negedge clk);
      chk("start_in_done_ignored", busy, 0);

      // reset during WAIT of pixel 5
      n0 = done_cnt;
      start_frame(31'($urandom));
      while (cyc < t_start + 5 * PER + 1) @(negedge clk);
      chk("pre_reset_writes", q.size(), NPIX - 5);
      rst = 1'b1;
      #1;
      check_zero("midrst");
      q.delete();
      exp_done = -1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("no_done_after_abort", done_cnt, n0);

      // fresh and random frames
      for (int f = 0; f < 3; f++) begin
         n0 = done_cnt;
         start_frame(31'($urandom));
         wait_done(n0);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
